// File: rtl/nn_pkg.sv
// Shared constants and types for the classifier datapath.
// Layer 2 geometry, logit format and the argmax reader state encoding.
package nn_pkg;

    localparam int NUM_L2_OUT = 10;
    localparam int LOGIT_W    = 6;
    localparam int CLASS_W    = 4;

    localparam logic [3:0] STREAM_TRAILER_TAG = 4'hC;

    typedef logic signed [LOGIT_W-1:0] logit_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        STREAM = 2'd2
    } reader_state_e;

endpackage

// File: rtl/layer2_argmax_reader.sv
// Scans the Layer 2 logits after completion, reports the argmax class and its logit,
// and optionally streams every logit plus a class trailer byte over a valid/ready port.
module layer2_argmax_reader #(
    parameter int NUM_CLASSES = nn_pkg::NUM_L2_OUT,
    parameter int LOGIT_W     = nn_pkg::LOGIT_W,
    parameter int ADDR_W      = nn_pkg::CLASS_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      l2_done,
    input  logic                      clear,
    input  logic                      stream_en,
    output logic [ADDR_W-1:0]         read_addr,
    input  logic signed [LOGIT_W-1:0] read_data,
    output logic [ADDR_W-1:0]         pred_class,
    output logic signed [LOGIT_W-1:0] pred_max,
    output logic                      pred_valid,
    output logic                      busy,
    output logic [7:0]                out_byte,
    output logic                      out_valid,
    input  logic                      out_ready
);

    import nn_pkg::*;

    // Stream byte counter runs 0..NUM_CLASSES+1; the last value means "trailer loaded".
    localparam int CNT_W = $clog2(NUM_CLASSES + 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_CLASSES - 1);
    localparam logic [CNT_W-1:0]  TRAILER_IDX = CNT_W'(NUM_CLASSES);
    localparam logic [CNT_W-1:0]  FINAL_IDX   = CNT_W'(NUM_CLASSES + 1);

    reader_state_e              state_q, state_d;
    logic                       done_q;
    logic                       stream_q, stream_d;
    logic [ADDR_W-1:0]          read_addr_q, read_addr_d;
    logic signed [LOGIT_W-1:0]  run_max_q, run_max_d;
    logic [ADDR_W-1:0]          run_class_q, run_class_d;
    logic [ADDR_W-1:0]          pred_class_q, pred_class_d;
    logic signed [LOGIT_W-1:0]  pred_max_q, pred_max_d;
    logic                       pred_valid_q, pred_valid_d;
    logic                       busy_q, busy_d;
    logic [7:0]                 out_byte_q, out_byte_d;
    logic                       out_valid_q, out_valid_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       done_rise;

    assign done_rise = l2_done & ~done_q;

    always_comb begin
        state_d      = state_q;
        stream_d     = stream_q;
        read_addr_d  = read_addr_q;
        run_max_d    = run_max_q;
        run_class_d  = run_class_q;
        pred_class_d = pred_class_q;
        pred_max_d   = pred_max_q;
        pred_valid_d = pred_valid_q;
        busy_d       = busy_q;
        out_byte_d   = out_byte_q;
        out_valid_d  = out_valid_q;
        cnt_d        = cnt_q;

        if (clear) begin
            state_d      = IDLE;
            pred_valid_d = 1'b0;
            out_valid_d  = 1'b0;
            busy_d       = 1'b0;
            read_addr_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (done_rise) begin
                        state_d      = SCAN;
                        read_addr_d  = '0;
                        pred_valid_d = 1'b0;
                        busy_d       = 1'b1;
                        stream_d     = stream_en;
                    end
                end

                SCAN: begin
                    // Strict greater-than keeps the lowest index on ties.
                    if (read_addr_q == '0 || read_data > run_max_q) begin
                        run_max_d   = read_data;
                        run_class_d = read_addr_q;
                    end
                    if (read_addr_q == LAST_ADDR) begin
                        pred_class_d = run_class_d;
                        pred_max_d   = run_max_d;
                        pred_valid_d = 1'b1;
                        read_addr_d  = '0;
                        cnt_d        = '0;
                        if (stream_q) begin
                            state_d = STREAM;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        read_addr_d = read_addr_q + 1'b1;
                    end
                end

                STREAM: begin
                    if (out_valid_q && out_ready && cnt_q == FINAL_IDX) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        read_addr_d = '0;
                    end else if (!out_valid_q || out_ready) begin
                        out_valid_d = 1'b1;
                        cnt_d       = cnt_q + 1'b1;
                        if (cnt_q < TRAILER_IDX) begin
                            out_byte_d = 8'(read_data);
                            // Hold at the last index rather than stepping out of range.
                            if (read_addr_q != LAST_ADDR) begin
                                read_addr_d = read_addr_q + 1'b1;
                            end
                        end else begin
                            out_byte_d = 8'({STREAM_TRAILER_TAG, pred_class_q});
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            stream_q     <= 1'b0;
            read_addr_q  <= '0;
            run_max_q    <= '0;
            run_class_q  <= '0;
            pred_class_q <= '0;
            pred_max_q   <= '0;
            pred_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            out_byte_q   <= '0;
            out_valid_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            done_q       <= l2_done;
            stream_q     <= stream_d;
            read_addr_q  <= read_addr_d;
            run_max_q    <= run_max_d;
            run_class_q  <= run_class_d;
            pred_class_q <= pred_class_d;
            pred_max_q   <= pred_max_d;
            pred_valid_q <= pred_valid_d;
            busy_q       <= busy_d;
            out_byte_q   <= out_byte_d;
            out_valid_q  <= out_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign read_addr  = read_addr_q;
    assign pred_class = pred_class_q;
    assign pred_max   = pred_max_q;
    assign pred_valid = pred_valid_q;
    assign busy       = busy_q;
    assign out_byte   = out_byte_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_layer2_argmax_reader.sv
// Self-checking bench for layer2_argmax_reader: directed table, randomized scans
// against an argmax/stream reference model, and clear/reset corner sequences.
module tb_layer2_argmax_reader;

    typedef logic [9:0][5:0] lvec_t;

    typedef struct packed {
        lvec_t       l;
        logic [3:0]  expClass;
        logic [5:0]  expMax;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              l2_done = 1'b0;
    logic              clear = 1'b0;
    logic              stream_en = 1'b0;
    logic [3:0]        read_addr;
    logic signed [5:0] read_data;
    logic [3:0]        pred_class;
    logic signed [5:0] pred_max;
    logic              pred_valid;
    logic              busy;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              out_ready = 1'b1;

    logic signed [5:0] mem [16];
    int checks = 0;
    int failures = 0;
    int addrErr = 0;
    int lastCls = 0;
    int lastMax = 0;

    layer2_argmax_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .l2_done    (l2_done),
        .clear      (clear),
        .stream_en  (stream_en),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .pred_class (pred_class),
        .pred_max   (pred_max),
        .pred_valid (pred_valid),
        .busy       (busy),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    assign read_data = mem[read_addr];

    always @(negedge clk) begin
        if (rst_n && read_addr >= 4'd10) addrErr++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic lvec_t mk(input int a0, input int a1, input int a2, input int a3,
                                 input int a4, input int a5, input int a6, input int a7,
                                 input int a8, input int a9);
        int a[10];
        a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8, a9};
        for (int i = 0; i < 10; i++) mk[i] = 6'(a[i]);
    endfunction

    function automatic lvec_t randVec(input int lo, input int hi);
        for (int i = 0; i < 10; i++) randVec[i] = 6'($urandom_range(hi, lo) - 32);
    endfunction

    // Argmax with first occurrence winning, done with plain integers.
    task automatic refModel(input lvec_t l, output int cls, output int mx);
        int v;
        mx = -1000;
        cls = 0;
        for (int i = 0; i < 10; i++) begin
            v = $signed(l[i]);
            if (v > mx) begin
                mx = v;
                cls = i;
            end
        end
    endtask

    task automatic loadMem(input lvec_t l);
        for (int i = 0; i < 16; i++) mem[i] = (i < 10) ? $signed(l[i]) : 6'sd0;
    endtask

    task automatic pulseDone();
        @(negedge clk) l2_done = 1'b1;
        @(negedge clk) l2_done = 1'b0;
    endtask

    task automatic collectStream(input lvec_t l, input int cls, input bit rnd, input string tag);
        logic [7:0] got[$];
        logic [7:0] prevB = 8'h00;
        bit stalled = 1'b0;
        int n = 0;
        int stallErr = 0;
        int validCycles = 0;
        int v;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
            if (stalled && (!out_valid || out_byte != prevB)) stallErr++;
            if (out_valid) validCycles++;
            out_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            if (out_valid && out_ready) got.push_back(out_byte);
            stalled = out_valid && !out_ready;
            prevB = out_byte;
        end
        out_ready = 1'b1;
        check({tag, "_streamEnd"}, int'(busy), 0);
        check({tag, "_byteCount"}, got.size(), 11);
        if (got.size() == 11) begin
            for (int i = 0; i < 10; i++) begin
                v = $signed(l[i]);
                check($sformatf("%s_byte%0d", tag, i), int'(got[i]), v & 255);
            end
            check({tag, "_trailer"}, int'(got[10]), 8'hC0 | cls);
        end
        check({tag, "_stallStable"}, stallErr, 0);
        if (!rnd) check({tag, "_backToBack"}, validCycles, 11);
        check({tag, "_outValidLow"}, int'(out_valid), 0);
    endtask

    task automatic runScan(input lvec_t l, input bit se, input bit rnd, input string tag);
        int cls, mx, cycles;
        refModel(l, cls, mx);
        loadMem(l);
        stream_en = se;
        out_ready = 1'b1;
        pulseDone();
        check({tag, "_pvLowInScan"}, int'(pred_valid), 0);
        check({tag, "_busyInScan"}, int'(busy), 1);
        cycles = 0;
        while (!pred_valid && cycles < 30) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, "_latency"}, cycles, 10);
        check({tag, "_class"}, int'(pred_class), cls);
        check({tag, "_max"}, int'(pred_max), mx);
        check({tag, "_busyAtValid"}, int'(busy), int'(se));
        lastCls = cls;
        lastMax = mx;
        if (se) begin
            collectStream(l, cls, rnd, tag);
            check({tag, "_pvAfterStream"}, int'(pred_valid), 1);
        end
        stream_en = 1'b0;
    endtask

    task automatic applyStimulus();
        vec_t tbl[4];
        lvec_t v1;
        int sweeps, cnt, acc;
        v1 = mk(-3, 5, 2, 5, 0, -1, 4, -32, 1, 3);
        tbl[0] = '{l: v1, expClass: 4'd1, expMax: 6'd5};
        tbl[1] = '{l: mk(-32, -32, -32, -32, -32, -32, -32, -32, -32, -32), expClass: 4'd0, expMax: 6'(-32)};
        tbl[2] = '{l: mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 31), expClass: 4'd9, expMax: 6'd31};
        tbl[3] = '{l: mk(-5, -7, 12, -1, 12, 30, 30, 2, 0, 30), expClass: 4'd5, expMax: 6'd30};

        loadMem(v1);
        #12;
        check("rst_readAddr", int'(read_addr), 0);
        check("rst_predClass", int'(pred_class), 0);
        check("rst_predMax", int'(pred_max), 0);
        check("rst_predValid", int'(pred_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_outByte", int'(out_byte), 0);
        check("rst_outValid", int'(out_valid), 0);
        rst_n = 1'b1;

        for (int t = 0; t < 4; t++) begin
            runScan(tbl[t].l, 1'b0, 1'b0, $sformatf("tbl%0d", t));
            check($sformatf("tbl%0d_classTbl", t), int'(pred_class), int'(tbl[t].expClass));
            check($sformatf("tbl%0d_maxTbl", t), int'(pred_max), int'($signed(tbl[t].expMax)));
        end

        // Held-high completion flag: exactly one sweep.
        loadMem(tbl[2].l);
        sweeps = 0;
        @(negedge clk) l2_done = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (read_addr == 4'd9) sweeps++;
        end
        check("held_sweeps", sweeps, 1);
        check("held_class", int'(pred_class), 9);
        @(negedge clk) l2_done = 1'b0;
        runScan(v1, 1'b0, 1'b0, "rescan");

        runScan(v1, 1'b1, 1'b0, "stream");
        runScan(v1, 1'b1, 1'b1, "streamRnd");

        for (int r = 0; r < 6; r++) begin
            runScan(randVec((r % 2) ? 28 : 0, (r % 2) ? 36 : 63), r[0], r[1],
                    $sformatf("rand%0d", r));
        end

        // Clear during scan.
        loadMem(v1);
        stream_en = 1'b1;
        pulseDone();
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        check("clr_predValid", int'(pred_valid), 0);
        check("clr_busy", int'(busy), 0);
        check("clr_readAddr", int'(read_addr), 0);
        check("clr_keepClass", int'(pred_class), lastCls);
        check("clr_keepMax", int'(pred_max), lastMax);
        cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid || busy || pred_valid) cnt++;
        end
        check("clr_noActivity", cnt, 0);

        // Clear coincident with the rise consumes it.
        @(negedge clk) begin
            l2_done = 1'b1;
            clear = 1'b1;
        end
        @(negedge clk) clear = 1'b0;
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        check("clrRise_noScan", cnt, 0);
        @(negedge clk) l2_done = 1'b0;
        stream_en = 1'b0;

        // Asynchronous reset mid-stream.
        loadMem(v1);
        stream_en = 1'b1;
        pulseDone();
        acc = 0;
        cnt = 0;
        while (acc < 3 && cnt < 60) begin
            @(negedge clk);
            cnt++;
            if (out_valid && out_ready) acc++;
        end
        check("midRst_reachedByte3", acc, 3);
        #2 rst_n = 1'b0;
        #1;
        check("midRst_outValid", int'(out_valid), 0);
        check("midRst_outByte", int'(out_byte), 0);
        check("midRst_busy", int'(busy), 0);
        check("midRst_predValid", int'(pred_valid), 0);
        check("midRst_predClass", int'(pred_class), 0);
        check("midRst_predMax", int'(pred_max), 0);
        check("midRst_readAddr", int'(read_addr), 0);
        stream_en = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        runScan(randVec(0, 63), 1'b1, 1'b0, "postRst");
    endtask

    task automatic checkOutput();
        check("addrInRange", addrErr, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        applyStimulus();
        checkOutput();
        $finish;
    end

endmodule
